dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory (MemWrite/MemRead/Addr/Wdata/Rdata interface).
- Port 0 is the pipeline MEM stage; port 1 is the loader/DMA.
- Registers every memory command, enforces one access per grant, guards the address range, and returns read data with a fixed latency.
- Sits between the MEM stage and the data memory; the memory is a combinational-read array.

Parameters:
- DEPTH, 128, number of 32-bit memory words; legal addresses are 0..DEPTH-1.
- FIXED_PRIO, 1, 1 = port 0 always wins ties; 0 = round-robin on ties.
- MAX_WAIT, 4, idle-state arbitrations port 1 may lose before it is force-granted (only when FIXED_PRIO=1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request; held with we0/addr0/wdata0 stable until gnt0.
- we0  in  1  port 0: 1 = write, 0 = read.
- addr0  in  32  port 0 word address.
- wdata0  in  32  port 0 write data.
- gnt0  out  1  port 0 command issued this cycle (one-cycle pulse).
- rvalid0  out  1  port 0 read data valid on rdata (one-cycle pulse).
- req1, we1, addr1, wdata1, gnt1, rvalid1  same as port 0, for port 1.
- rdata  out  32  registered read data, shared by both ports.
- addr_err  out  1  sticky flag: an out-of-range access was issued; cleared only by reset.
- MemWrite  out  1  memory write strobe.
- MemRead  out  1  memory read strobe.
- Addr  out  32  memory address.
- Wdata  out  32  memory write data.
- Rdata  in  32  memory read data (combinational from Addr).

Behaviour:
- Reset (async, any time, including mid-access): state=IDLE; all outputs 0; wait counter 0; round-robin pointer = port 0. An in-flight access is dropped and no rvalid follows.
- FSM has two states, IDLE and ISSUE.
- IDLE, no req: stay in IDLE; MemRead/MemWrite=0.
- IDLE, any req at a clock edge: choose a winner; next state=ISSUE.
- Arbitration winner:
  - Only one port requesting: that port wins.
  - Both requesting, FIXED_PRIO=1: port 0 wins, unless the wait counter equals MAX_WAIT, then port 1 wins.
  - Both requesting, FIXED_PRIO=0: the port not granted last wins.
- Wait counter (3+ bits):
  - Increments at each IDLE edge where port 1 requests and loses.
  - Clears when port 1 is granted.
  - Saturates at MAX_WAIT.
- ISSUE, one cycle long:
  - gnt of the winner = 1.
  - Addr/Wdata = the winner's registered addr/wdata.
  - MemWrite = we & in-range; MemRead = ~we & in-range.
  - Next state is always IDLE. No back-to-back issue, so a requester sampled again at the ISSUE edge is never double-issued.
  - Peak throughput is one access per 2 cycles.
- Read return:
  - At the edge ending ISSUE, rdata <= in-range ? Rdata : 0.
  - rvalid of the winner = 1 for the following cycle.
  - Latency from the req-sampling edge to rvalid is 2 cycles.
  - rdata holds its value until the next read completes.
- Writes produce no rvalid.
- Out-of-range (addr >= DEPTH):
  - Command is issued (gnt pulses) but both strobes stay 0.
  - A read returns rdata=0 with rvalid.
  - addr_err is set at the end of ISSUE.
- A req deasserted before its grant is allowed; the request is simply withdrawn.
- Requests are never dropped: any req held high is granted within MAX_WAIT+1 arbitrations.

Test Plan:
- Reset released, port 0 write addr=5 wdata=0xDEADBEEF, then read addr=5 -> gnt0 pulses each access; MemWrite=1 only in the write ISSUE cycle; read gives rvalid0 2 cycles after sampling with rdata=0xDEADBEEF.
- req0 and req1 held high with FIXED_PRIO=1, MAX_WAIT=4 -> grant order 0,0,0,0,1,0,0,0,0,1; wait counter clears after each port-1 grant.
- FIXED_PRIO=0, both requesting continuously -> grants alternate 1,0,1,0 (pointer starts at port 0, so port 1 wins the first tie); one issue every 2 cycles; never two gnt pulses in consecutive cycles.
- Port 1 read addr=200 (DEPTH=128) -> gnt1 pulses; MemRead=0; rvalid1 with rdata=0; addr_err=1 and stays 1 until rst_n low.
- rst_n pulled low during ISSUE of a port-0 read -> all outputs 0 immediately; no rvalid0 after release; next request is serviced normally.
- req0 raised then dropped before its sampling edge -> no gnt0, no memory strobe, state stays IDLE.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle for dmem_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface dmem_arbiter_if;
  logic        req0, we0, gnt0, rvalid0;
  logic [31:0] addr0, wdata0;
  logic        req1, we1, gnt1, rvalid1;
  logic [31:0] addr1, wdata1;
  logic [31:0] rdata;
  logic        addr_err;
  logic        MemWrite, MemRead;
  logic [31:0] Addr, Wdata, Rdata;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, Rdata,
    output gnt0, rvalid0, gnt1, rvalid1, rdata, addr_err,
           MemWrite, MemRead, Addr, Wdata
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, Rdata,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata, addr_err,
           MemWrite, MemRead, Addr, Wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port, combinational-read data memory.
// Each access takes one IDLE arbitration cycle plus one ISSUE cycle; read data returns registered.
module dmem_arbiter #(
  parameter int DEPTH      = 128,
  parameter int FIXED_PRIO = 1,
  parameter int MAX_WAIT   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);
  localparam int WW = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          inr_q, inr_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          last_q, last_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rv0_q, rv0_d;
  logic          rv1_q, rv1_d;
  logic          err_q, err_d;
  logic          pick;
  logic          issue;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    inr_d   = inr_q;
    wait_d  = wait_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    err_d   = err_q;
    pick    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Ties: fixed priority with a starvation override, or alternate against the last grant.
          if (bus.req0 && bus.req1)
            pick = (FIXED_PRIO != 0) ? (wait_q == WMAX) : ~last_q;
          else
            pick = bus.req1;
          state_d = S_ISSUE;
          win_d   = pick;
          last_d  = pick;
          we_d    = pick ? bus.we1    : bus.we0;
          addr_d  = pick ? bus.addr1  : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          inr_d   = (addr_d < 32'(DEPTH));
          if (pick)
            wait_d = '0;
          else if (bus.req1 && (wait_q != WMAX))
            wait_d = wait_q + WW'(1);
        end
      end
      S_ISSUE: begin
        state_d = S_IDLE;
        if (!we_q) begin
          rdata_d = inr_q ? bus.Rdata : '0;
          rv0_d   = ~win_q;
          rv1_d   = win_q;
        end
        if (!inr_q)
          err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      inr_q   <= 1'b0;
      wait_q  <= '0;
      last_q  <= 1'b0;
      rdata_q <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      inr_q   <= inr_d;
      wait_q  <= wait_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      err_q   <= err_d;
    end
  end

  assign issue        = (state_q == S_ISSUE);
  assign bus.gnt0     = issue & ~win_q;
  assign bus.gnt1     = issue &  win_q;
  assign bus.MemWrite = issue &  we_q & inr_q;
  assign bus.MemRead  = issue & ~we_q & inr_q;
  assign bus.Addr     = issue ? addr_q  : '0;
  assign bus.Wdata    = issue ? wdata_q : '0;
  assign bus.rvalid0  = rv0_q;
  assign bus.rvalid1  = rv1_q;
  assign bus.rdata    = rdata_q;
  assign bus.addr_err = err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one fixed-priority and one round-robin instance driven side by side,
// checked cycle by cycle against a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int          MAXW    = 4;
  localparam logic [31:0] DEPTH_W = 32'd128;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_v [2][2];
  logic        we_v  [2][2];
  logic [31:0] addr_v[2][2];
  logic [31:0] wd_v  [2][2];
  logic [1:0]  gnt_o [2];
  logic [1:0]  rv_o  [2];
  logic [31:0] rdata_o[2], maddr_o[2], mwd_o[2];
  logic        err_o[2], mw_o[2], mr_o[2];
  logic [31:0] env_mem[2][128];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter_if bus_i ();
    dmem_arbiter #(.DEPTH(128), .FIXED_PRIO((g == 0) ? 1 : 0), .MAX_WAIT(MAXW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_i)
    );
    assign bus_i.req0   = req_v[g][0];
    assign bus_i.we0    = we_v[g][0];
    assign bus_i.addr0  = addr_v[g][0];
    assign bus_i.wdata0 = wd_v[g][0];
    assign bus_i.req1   = req_v[g][1];
    assign bus_i.we1    = we_v[g][1];
    assign bus_i.addr1  = addr_v[g][1];
    assign bus_i.wdata1 = wd_v[g][1];
    assign bus_i.Rdata  = (bus_i.Addr < DEPTH_W) ? env_mem[g][bus_i.Addr[6:0]] : 32'hBAD0_BAD0;
    assign gnt_o[g]     = {bus_i.gnt1, bus_i.gnt0};
    assign rv_o[g]      = {bus_i.rvalid1, bus_i.rvalid0};
    assign rdata_o[g]   = bus_i.rdata;
    assign err_o[g]     = bus_i.addr_err;
    assign mw_o[g]      = bus_i.MemWrite;
    assign mr_o[g]      = bus_i.MemRead;
    assign maddr_o[g]   = bus_i.Addr;
    assign mwd_o[g]     = bus_i.Wdata;
  end

  // Reference model state, per instance k (0 = fixed priority, 1 = round robin).
  txn_t        tq[2][2][$];
  bit          cv[2][2];
  txn_t        cur[2][2];
  bit          iss_v[2];
  int          iss_p[2];
  txn_t        iss_t[2];
  bit          rv_v[2];
  int          rv_p[2];
  logic [31:0] rd_m[2];
  int          wait_m[2];
  int          last_m[2];
  bit          err_m[2];
  logic [31:0] ref_mem[2][128];
  int          glog[2][$];
  int          withdraw_pct = 0;
  int          gap_pct = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic txn_t rand_txn(input bit allow_oor);
    txn_t t;
    int   sel;
    sel     = int'($urandom_range(0, 7));
    t.we    = 1'($urandom_range(0, 1));
    t.wdata = $urandom;
    if (allow_oor && sel == 0)      t.addr = $urandom | 32'h8000_0000;
    else if (allow_oor && sel <= 2) t.addr = 32'($urandom_range(120, 140));
    else                            t.addr = 32'($urandom_range(0, 127));
    return t;
  endfunction

  task automatic drive_ports();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        req_v[k][p]  = cv[k][p];
        we_v[k][p]   = cur[k][p].we;
        addr_v[k][p] = cur[k][p].addr;
        wd_v[k][p]   = cur[k][p].wdata;
      end
  endtask

  // One clock: compare this cycle's outputs, present next requests, advance the model over the next edge.
  task automatic tick();
    bit inr;
    bit dropped;
    int w;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      inr = iss_v[k] && (iss_t[k].addr < DEPTH_W);
      check_eq($sformatf("gnt0_%0d", k), 32'(gnt_o[k][0]), 32'(iss_v[k] && iss_p[k] == 0));
      check_eq($sformatf("gnt1_%0d", k), 32'(gnt_o[k][1]), 32'(iss_v[k] && iss_p[k] == 1));
      check_eq($sformatf("memwrite_%0d", k), 32'(mw_o[k]), 32'(inr && iss_t[k].we));
      check_eq($sformatf("memread_%0d", k), 32'(mr_o[k]), 32'(inr && !iss_t[k].we));
      if (iss_v[k]) begin
        check_eq($sformatf("addr_%0d", k), maddr_o[k], iss_t[k].addr);
        if (iss_t[k].we) check_eq($sformatf("wdata_%0d", k), mwd_o[k], iss_t[k].wdata);
      end
      check_eq($sformatf("rvalid0_%0d", k), 32'(rv_o[k][0]), 32'(rv_v[k] && rv_p[k] == 0));
      check_eq($sformatf("rvalid1_%0d", k), 32'(rv_o[k][1]), 32'(rv_v[k] && rv_p[k] == 1));
      check_eq($sformatf("rdata_%0d", k), rdata_o[k], rd_m[k]);
      check_eq($sformatf("addr_err_%0d", k), 32'(err_o[k]), 32'(err_m[k]));
      if (gnt_o[k][0]) glog[k].push_back(0);
      if (gnt_o[k][1]) glog[k].push_back(1);
      if (mw_o[k] && maddr_o[k] < DEPTH_W) env_mem[k][maddr_o[k][6:0]] = mwd_o[k];
    end

    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        dropped = 1'b0;
        if (iss_v[k] && iss_p[k] == p) cv[k][p] = 1'b0;
        else if (cv[k][p] && int'($urandom_range(0, 99)) < withdraw_pct) begin
          cv[k][p] = 1'b0;
          dropped  = 1'b1;
        end
        if (!cv[k][p] && !dropped && tq[k][p].size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
          cur[k][p] = tq[k][p].pop_front();
          cv[k][p]  = 1'b1;
        end
      end
    drive_ports();

    for (int k = 0; k < 2; k++) begin
      if (iss_v[k]) begin
        inr      = iss_t[k].addr < DEPTH_W;
        rv_v[k]  = !iss_t[k].we;
        rv_p[k]  = iss_p[k];
        if (!iss_t[k].we) rd_m[k] = inr ? ref_mem[k][iss_t[k].addr[6:0]] : 32'h0;
        if (iss_t[k].we && inr) ref_mem[k][iss_t[k].addr[6:0]] = iss_t[k].wdata;
        if (!inr) err_m[k] = 1'b1;
        iss_v[k] = 1'b0;
      end else begin
        rv_v[k] = 1'b0;
        if (cv[k][0] || cv[k][1]) begin
          if (cv[k][0] && cv[k][1]) w = (k == 0) ? ((wait_m[k] == MAXW) ? 1 : 0) : 1 - last_m[k];
          else                      w = cv[k][1] ? 1 : 0;
          if (w == 1)                            wait_m[k] = 0;
          else if (cv[k][1] && wait_m[k] < MAXW) wait_m[k]++;
          last_m[k] = w;
          iss_v[k]  = 1'b1;
          iss_p[k]  = w;
          iss_t[k]  = cur[k][w];
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_gnt_%0d", k), 32'(gnt_o[k]), 32'h0);
      check_eq($sformatf("rst_rvalid_%0d", k), 32'(rv_o[k]), 32'h0);
      check_eq($sformatf("rst_rdata_%0d", k), rdata_o[k], 32'h0);
      check_eq($sformatf("rst_addr_err_%0d", k), 32'(err_o[k]), 32'h0);
      check_eq($sformatf("rst_strobes_%0d", k), 32'({mw_o[k], mr_o[k]}), 32'h0);
      check_eq($sformatf("rst_Addr_%0d", k), maddr_o[k], 32'h0);
      check_eq($sformatf("rst_Wdata_%0d", k), mwd_o[k], 32'h0);
      iss_v[k] = 1'b0; rv_v[k] = 1'b0; rd_m[k] = '0;
      wait_m[k] = 0; last_m[k] = 0; err_m[k] = 1'b0;
      glog[k].delete();
      for (int p = 0; p < 2; p++) begin
        cv[k][p] = 1'b0;
        cur[k][p] = '0;
        tq[k][p].delete();
      end
    end
    drive_ports();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_fp[10];
    int exp_rr[4];
    int n;
    logic [31:0] v;
    txn_t t;
    exp_fp = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    exp_rr = '{1, 0, 1, 0};
    for (int i = 0; i < 128; i++) begin
      v = $urandom;
      env_mem[0][i] = v; env_mem[1][i] = v;
      ref_mem[0][i] = v; ref_mem[1][i] = v;
    end
    apply_reset();

    // Write then read address 5 on port 0.
    for (int k = 0; k < 2; k++) begin
      t = '{we: 1'b1, addr: 32'd5, wdata: 32'hDEAD_BEEF};
      tq[k][0].push_back(t);
      t = '{we: 1'b0, addr: 32'd5, wdata: 32'h0};
      tq[k][0].push_back(t);
    end
    repeat (8) tick();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rd5_data_%0d", k), rdata_o[k], 32'hDEAD_BEEF);
      check_eq($sformatf("rd5_grants_%0d", k), 32'(glog[k].size()), 32'd2);
    end

    // Both ports requesting continuously.
    apply_reset();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++)
        for (int i = 0; i < 12; i++) tq[k][p].push_back(rand_txn(1'b0));
    repeat (24) tick();
    check_eq("fp_grant_count", 32'(glog[0].size() >= 10), 32'd1);
    n = (glog[0].size() < 10) ? glog[0].size() : 10;
    for (int i = 0; i < n; i++) check_eq($sformatf("fp_order_%0d", i), 32'(glog[0][i]), 32'(exp_fp[i]));
    check_eq("rr_grant_count", 32'(glog[1].size() >= 4), 32'd1);
    n = (glog[1].size() < 4) ? glog[1].size() : 4;
    for (int i = 0; i < n; i++) check_eq($sformatf("rr_order_%0d", i), 32'(glog[1][i]), 32'(exp_rr[i]));

    // Range boundary: 127 is legal, 200 is not.
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      t = '{we: 1'b0, addr: 32'd127, wdata: 32'h0};
      tq[k][0].push_back(t);
      t = '{we: 1'b0, addr: 32'd200, wdata: 32'h0};
      tq[k][1].push_back(t);
      t = '{we: 1'b1, addr: 32'd128, wdata: 32'h1234_5678};
      tq[k][0].push_back(t);
    end
    repeat (10) tick();
    for (int k = 0; k < 2; k++) check_eq($sformatf("oor_err_%0d", k), 32'(err_o[k]), 32'h1);
    repeat (4) tick();

    // Request pulse that never reaches a sampling edge.
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      req_v[k][0] = 1'b1; we_v[k][0] = 1'b1; addr_v[k][0] = 32'd7; wd_v[k][0] = 32'hFFFF_FFFF;
    end
    #2;
    for (int k = 0; k < 2; k++) req_v[k][0] = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < 2; k++) check_eq($sformatf("glitch_grants_%0d", k), 32'(glog[k].size()), 32'd0);

    // Reset in the middle of a port-0 read issue, then normal service.
    for (int k = 0; k < 2; k++) begin
      t = '{we: 1'b0, addr: 32'd9, wdata: 32'h0};
      tq[k][0].push_back(t);
    end
    n = 0;
    while (!iss_v[0] && n < 10) begin
      tick();
      n++;
    end
    check_eq("mid_rst_reach_issue", 32'(iss_v[0]), 32'h1);
    @(posedge clk);
    #1;
    check_eq("mid_rst_gnt0", 32'(gnt_o[0][0]), 32'h1);
    apply_reset();
    repeat (4) tick();
    for (int k = 0; k < 2; k++) begin
      t = '{we: 1'b0, addr: 32'd9, wdata: 32'h0};
      tq[k][0].push_back(t);
    end
    repeat (6) tick();
    for (int k = 0; k < 2; k++) check_eq($sformatf("post_rst_rd9_%0d", k), rdata_o[k], ref_mem[k][9]);

    // Randomized traffic with gaps, withdrawals and out-of-range addresses.
    withdraw_pct = 5;
    gap_pct = 30;
    for (int i = 0; i < 80; i++)
      for (int p = 0; p < 2; p++) begin
        t = rand_txn(1'b1);
        tq[0][p].push_back(t);
        tq[1][p].push_back(t);
      end
    repeat (500) tick();
    withdraw_pct = 0;
    gap_pct = 0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
